// File: rtl/simd_host_loader.sv
// simd_host_loader
//   Host command engine around the SIMD datapath. Parses a 32-bit host word
//   stream (header + payload) into line writes for operand BRAMs A/B and the
//   instruction BRAM, pulses the datapath start and waits for done, and
//   streams result BRAM R back to the host one lane per beat.
// Ports
//   clk, rst                    : clock, synchronous active-high reset
//   s_data/s_valid/s_ready      : host command/payload stream in
//   m_data/m_valid/m_ready      : readback stream out
//   bram_{a,b}_wr_*             : operand line write port (lane 0 in LSBs)
//   bram_ins_wr_*               : instruction write port
//   bram_r_rd_addr/_rd_data     : result read port, 1-cycle latency
//   start/done                  : datapath handshake
//   busy, err                   : not idle / sticky bad-command flag
module simd_host_loader #(
  parameter int PE_COUNT       = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int INS_ADDR_WIDTH = 8,
  parameter int INS_WIDTH      = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_WIDTH-1:0]          s_data,
  input  logic                           s_valid,
  output logic                           s_ready,
  output logic [DATA_WIDTH-1:0]          m_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic                           bram_a_wr_en,
  output logic [ADDR_WIDTH-1:0]          bram_a_wr_addr,
  output logic [PE_COUNT*DATA_WIDTH-1:0] bram_a_wr_data,
  output logic                           bram_b_wr_en,
  output logic [ADDR_WIDTH-1:0]          bram_b_wr_addr,
  output logic [PE_COUNT*DATA_WIDTH-1:0] bram_b_wr_data,
  output logic                           bram_ins_wr_en,
  output logic [INS_ADDR_WIDTH-1:0]      bram_ins_wr_addr,
  output logic [INS_WIDTH-1:0]           bram_ins_wr_data,
  output logic [ADDR_WIDTH-1:0]          bram_r_rd_addr,
  input  logic [PE_COUNT*DATA_WIDTH-1:0] bram_r_rd_data,
  output logic                           start,
  input  logic                           done,
  output logic                           busy,
  output logic                           err
);
  localparam int LINE_W    = PE_COUNT*DATA_WIDTH;
  localparam int INS_BEATS = INS_WIDTH/DATA_WIDTH;
  localparam int MAX_BEATS = (PE_COUNT > INS_BEATS) ? PE_COUNT : INS_BEATS;
  localparam int BUF_W     = MAX_BEATS*DATA_WIDTH;
  localparam int BEAT_W    = $clog2(MAX_BEATS+1);
  localparam int LANE_W    = $clog2(PE_COUNT+1);

  localparam logic [2:0] CMD_LOAD_A = 3'd0, CMD_LOAD_B = 3'd1, CMD_LOAD_INS = 3'd2,
                         CMD_READ_R = 3'd3, CMD_RUN    = 3'd4;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_RD_ADDR, S_RD_WAIT, S_RD_SEND} state_t;

  state_t                 state_q, state_d;
  logic [2:0]             cmd_q, cmd_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [9:0]             rem_q, rem_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic [BUF_W-1:0]       line_q, line_d;
  logic                   wr_a_q, wr_a_d, wr_b_q, wr_b_d, wr_ins_q, wr_ins_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [BUF_W-1:0]       wr_data_q, wr_data_d;
  logic                   start_q, start_d;
  logic                   err_q, err_d;
  logic [LINE_W-1:0]      rd_line_q, rd_line_d;
  logic [LANE_W-1:0]      lane_q, lane_d;
  logic                   s_ready_c;
  logic [BEAT_W-1:0]      last_beat;

  // header low bits carry no information
  logic unused_hdr_bits;
  assign unused_hdr_bits = ^s_data[8:0];

  assign last_beat = (cmd_q == CMD_LOAD_INS) ? BEAT_W'(INS_BEATS-1) : BEAT_W'(PE_COUNT-1);

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    beat_d    = beat_q;
    line_d    = line_q;
    wr_a_d    = 1'b0;
    wr_b_d    = 1'b0;
    wr_ins_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    start_d   = 1'b0;
    err_d     = err_q;
    rd_line_d = rd_line_q;
    lane_d    = lane_q;
    s_ready_c = 1'b0;
    m_valid   = 1'b0;
    case (state_q)
      S_IDLE: begin
        s_ready_c = 1'b1;
        if (s_valid) begin
          cmd_d  = s_data[31:29];
          addr_d = ADDR_WIDTH'(s_data[28:19]);
          rem_d  = s_data[18:9];
          beat_d = '0;
          lane_d = '0;
          case (s_data[31:29])
            CMD_LOAD_A, CMD_LOAD_B, CMD_LOAD_INS: state_d = S_LOAD;
            CMD_READ_R: state_d = S_RD_ADDR;
            CMD_RUN: begin
              state_d = S_RUN;
              start_d = 1'b1;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      S_LOAD: begin
        s_ready_c = 1'b1;
        if (s_valid) begin
          for (int i = 0; i < MAX_BEATS; i++)
            if (beat_q == BEAT_W'(i)) line_d[i*DATA_WIDTH +: DATA_WIDTH] = s_data;
          if (beat_q == last_beat) begin
            // whole line assembled: register the strobe so it lands next cycle
            beat_d    = '0;
            wr_a_d    = (cmd_q == CMD_LOAD_A);
            wr_b_d    = (cmd_q == CMD_LOAD_B);
            wr_ins_d  = (cmd_q == CMD_LOAD_INS);
            wr_addr_d = addr_q;
            wr_data_d = line_d;
            addr_d    = addr_q + 1'b1;
            if (rem_q == '0) state_d = S_IDLE;
            else             rem_d   = rem_q - 1'b1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      // start_q marks the start cycle, where done is not looked at
      S_RUN: if (!start_q && done) state_d = S_IDLE;
      S_RD_ADDR: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        rd_line_d = bram_r_rd_data;
        lane_d    = '0;
        state_d   = S_RD_SEND;
      end
      S_RD_SEND: begin
        m_valid = 1'b1;
        if (m_ready) begin
          rd_line_d = rd_line_q >> DATA_WIDTH;
          if (lane_q == LANE_W'(PE_COUNT-1)) begin
            if (rem_q == '0) state_d = S_IDLE;
            else begin
              addr_d  = addr_q + 1'b1;
              rem_d   = rem_q - 1'b1;
              state_d = S_RD_ADDR;
            end
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cmd_q     <= '0;
      addr_q    <= '0;
      rem_q     <= '0;
      beat_q    <= '0;
      line_q    <= '0;
      wr_a_q    <= 1'b0;
      wr_b_q    <= 1'b0;
      wr_ins_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      start_q   <= 1'b0;
      err_q     <= 1'b0;
      rd_line_q <= '0;
      lane_q    <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      beat_q    <= beat_d;
      line_q    <= line_d;
      wr_a_q    <= wr_a_d;
      wr_b_q    <= wr_b_d;
      wr_ins_q  <= wr_ins_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      start_q   <= start_d;
      err_q     <= err_d;
      rd_line_q <= rd_line_d;
      lane_q    <= lane_d;
    end
  end

  // not ready while reset is held, even though state is already IDLE
  assign s_ready          = s_ready_c & ~rst;
  assign m_data           = rd_line_q[DATA_WIDTH-1:0];
  assign bram_a_wr_en     = wr_a_q;
  assign bram_a_wr_addr   = wr_addr_q;
  assign bram_a_wr_data   = wr_data_q[LINE_W-1:0];
  assign bram_b_wr_en     = wr_b_q;
  assign bram_b_wr_addr   = wr_addr_q;
  assign bram_b_wr_data   = wr_data_q[LINE_W-1:0];
  assign bram_ins_wr_en   = wr_ins_q;
  assign bram_ins_wr_addr = wr_addr_q[INS_ADDR_WIDTH-1:0];
  assign bram_ins_wr_data = wr_data_q[INS_WIDTH-1:0];
  assign bram_r_rd_addr   = addr_q;
  assign start            = start_q;
  assign busy             = (state_q != S_IDLE);
  assign err              = err_q;
endmodule
